// File: rtl/load_store_unit_if.sv
// CPU-side request/response bundle and word-wide memory bus for the load/store unit.
// master drives the request on each bundle; slave answers it.

interface load_store_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, addr, wdata,
        input  rdata, done, stall, misalign, bus_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, addr, wdata,
        output rdata, done, stall, misalign, bus_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: turns CPU load/store requests into word-wide req/ack memory
// transactions with byte lanes, misalignment detection and a timeout abort.

module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave cpu,
    lsu_mem_if.master        mem
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       lane_q, lane_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             misalign_q, misalign_d;
    logic             bus_err_q, bus_err_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic             req_misaligned;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata;
    logic [31:0]      rd_shifted;
    logic [31:0]      load_fmt;

    // Lane decode of the incoming request; reserved size 11 behaves as a word.
    always_comb begin
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        req_wdata      = cpu.wdata;
        case (cpu.req_size)
            2'b00: begin
                req_be    = 4'b0001 << cpu.addr[1:0];
                req_wdata = {4{cpu.wdata[7:0]}};
            end
            2'b01: begin
                req_be         = 4'b0011 << {cpu.addr[1], 1'b0};
                req_wdata      = {2{cpu.wdata[15:0]}};
                req_misaligned = cpu.addr[0];
            end
            default: begin
                req_misaligned = |cpu.addr[1:0];
            end
        endcase
    end

    always_comb begin
        rd_shifted = mem.mem_rdata >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   load_fmt = uns_q ? {24'd0, rd_shifted[7:0]}
                                      : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   load_fmt = uns_q ? {16'd0, rd_shifted[15:0]}
                                      : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_fmt = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (cpu.req_valid) begin
                    size_d = cpu.req_size;
                    uns_d  = cpu.req_unsigned;
                    lane_d = cpu.addr[1:0];
                    if (req_misaligned) begin
                        misalign_d = 1'b1;
                        done_d     = 1'b1;
                        rdata_d    = 32'd0;
                        state_d    = S_DONE;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = cpu.req_we;
                        mem_addr_d  = {cpu.addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata;
                        cnt_d       = '0;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // An ack arriving on the last allowed cycle still completes normally.
                if (mem.mem_ack) begin
                    mem_req_d = 1'b0;
                    rdata_d   = mem_we_q ? 32'd0 : load_fmt;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    rdata_d   = 32'd0;
                    bus_err_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu.rdata     = rdata_q;
    assign cpu.done      = done_q;
    assign cpu.misalign  = misalign_q;
    assign cpu.bus_err   = bus_err_q;
    assign cpu.stall     = cpu.req_valid & ~done_q;

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses against
// a byte-lane reference model and a shadow copy of data memory.

module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if cpu_if();
    lsu_mem_if         mem_if();

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .cpu (cpu_if),
        .mem (mem_if)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [0:63];
    logic [31:0] ref_mem [0:63];

    typedef struct {
        int          done_cyc;
        int          req_cycles;
        bit          req_seen;
        bit          stall_ok;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
    } obs_t;

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic exp_mis(input logic [1:0] size, input logic [1:0] lane);
        return (int'(lane) % size_bytes(size)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [1:0] lane);
        int n;
        n = size_bytes(size);
        return 4'(((1 << n) - 1) << (int'(lane) & ~(n - 1)));
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'b00) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (size == 2'b01) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] lane, input logic uns);
        int          n;
        logic [31:0] v;
        n = size_bytes(size);
        if (n == 4) return word;
        v = (word >> (8 * (int'(lane) & ~(n - 1)))) & ((32'd1 << (8 * n)) - 32'd1);
        if (!uns && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        mem_arr[idx] = val;
        ref_mem[idx] = val;
    endtask

    task automatic ref_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] w;
        be = exp_be(size, a[1:0]);
        w  = exp_wd(size, wd);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a[7:2]][8*b +: 8] = w[8*b +: 8];
    endtask

    // Drives one request and plays the memory: acks after ack_delay cycles of mem_req (-1 = never).
    task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_delay, output obs_t o);
        int idx;
        o.done_cyc = -1; o.req_cycles = 0; o.req_seen = 0; o.stall_ok = 1;
        o.we = 0; o.maddr = 0; o.be = 0; o.mwdata = 0; o.rdata = 0; o.mis = 0; o.berr = 0;
        @(negedge clk);
        cpu_if.req_valid = 1'b1; cpu_if.req_we = we; cpu_if.req_size = size;
        cpu_if.req_unsigned = uns; cpu_if.addr = a; cpu_if.wdata = wd;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            mem_if.mem_ack   = 1'b0;
            mem_if.mem_rdata = $urandom;
            if (cpu_if.done === 1'b1) begin
                o.done_cyc = c; o.rdata = cpu_if.rdata;
                o.mis = cpu_if.misalign; o.berr = cpu_if.bus_err;
                if (cpu_if.stall !== 1'b0) o.stall_ok = 0;
                break;
            end
            if (cpu_if.stall !== 1'b1) o.stall_ok = 0;
            if (mem_if.mem_req === 1'b1) begin
                if (!o.req_seen) begin
                    o.we = mem_if.mem_we; o.maddr = mem_if.mem_addr;
                    o.be = mem_if.mem_be; o.mwdata = mem_if.mem_wdata;
                end
                o.req_seen = 1;
                if (o.req_cycles == ack_delay) begin
                    mem_if.mem_ack = 1'b1;
                    idx = int'(mem_if.mem_addr[7:2]);
                    if (mem_if.mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_if.mem_be[b]) mem_arr[idx][8*b +: 8] = mem_if.mem_wdata[8*b +: 8];
                    end else begin
                        mem_if.mem_rdata = mem_arr[idx];
                    end
                end
                o.req_cycles++;
            end
        end
        cpu_if.req_valid = 1'b0;
        mem_if.mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got [0:9];
        string       nm  [0:9];
        rst = 1'b0;
        repeat (3) @(negedge clk);
        got[0] = cpu_if.rdata;           nm[0] = "rst_rdata";
        got[1] = {31'd0, cpu_if.done};   nm[1] = "rst_done";
        got[2] = {31'd0, cpu_if.misalign}; nm[2] = "rst_misalign";
        got[3] = {31'd0, cpu_if.bus_err}; nm[3] = "rst_bus_err";
        got[4] = {31'd0, mem_if.mem_req}; nm[4] = "rst_mem_req";
        got[5] = {31'd0, mem_if.mem_we};  nm[5] = "rst_mem_we";
        got[6] = mem_if.mem_addr;         nm[6] = "rst_mem_addr";
        got[7] = {28'd0, mem_if.mem_be};  nm[7] = "rst_mem_be";
        got[8] = mem_if.mem_wdata;        nm[8] = "rst_mem_wdata";
        got[9] = {31'd0, cpu_if.stall};   nm[9] = "rst_stall_idle";
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] !== 32'd0) begin errors++; $display("[TB] FAIL %s got %h want 0", nm[i], got[i]); end
        end
        cpu_if.req_valid = 1'b1;
        #1;
        checks++;
        if (cpu_if.stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall_follows got %b want 1", cpu_if.stall); end
        cpu_if.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_word_load();
        obs_t o;
        preload(0, 32'hDEADBEEF);
        run_access(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 0, o);
        checks++; if (o.maddr !== 32'h100) begin errors++; $display("[TB] FAIL wl_addr got %h want 00000100", o.maddr); end
        checks++; if (o.be !== 4'b1111) begin errors++; $display("[TB] FAIL wl_be got %b want 1111", o.be); end
        checks++; if (o.we !== 1'b0) begin errors++; $display("[TB] FAIL wl_we got %b want 0", o.we); end
        checks++; if (o.done_cyc != 2) begin errors++; $display("[TB] FAIL wl_latency got %0d want 2", o.done_cyc); end
        checks++; if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wl_rdata got %h want deadbeef", o.rdata); end
        checks++; if (!o.stall_ok) begin errors++; $display("[TB] FAIL wl_stall got bad want high-until-done"); end
    endtask

    task automatic test_byte_load();
        obs_t o;
        preload(0, 32'h80112233);
        run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 0, o);
        checks++; if (o.be !== 4'b1000) begin errors++; $display("[TB] FAIL bl_be got %b want 1000", o.be); end
        checks++; if (o.rdata !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL bl_signed got %h want ffffff80", o.rdata); end
        run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 1, o);
        checks++; if (o.rdata !== 32'h00000080) begin errors++; $display("[TB] FAIL bl_unsigned got %h want 00000080", o.rdata); end
        checks++; if (o.done_cyc != 3) begin errors++; $display("[TB] FAIL bl_latency got %0d want 3", o.done_cyc); end
    endtask

    task automatic test_half_store();
        obs_t o;
        run_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 0, o);
        ref_store(32'h202, 2'b01, 32'h1234ABCD);
        checks++; if (o.we !== 1'b1) begin errors++; $display("[TB] FAIL hs_we got %b want 1", o.we); end
        checks++; if (o.be !== 4'b1100) begin errors++; $display("[TB] FAIL hs_be got %b want 1100", o.be); end
        checks++; if (o.mwdata !== 32'hABCDABCD) begin errors++; $display("[TB] FAIL hs_wdata got %h want abcdabcd", o.mwdata); end
        checks++; if (o.maddr !== 32'h200) begin errors++; $display("[TB] FAIL hs_addr got %h want 00000200", o.maddr); end
        checks++; if (o.rdata !== 32'd0) begin errors++; $display("[TB] FAIL hs_rdata got %h want 0", o.rdata); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_access(1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 0, o);
        checks++; if (o.mis !== 1'b1) begin errors++; $display("[TB] FAIL mis_wl_flag got %b want 1", o.mis); end
        checks++; if (o.done_cyc != 1) begin errors++; $display("[TB] FAIL mis_wl_latency got %0d want 1", o.done_cyc); end
        checks++; if (o.req_seen) begin errors++; $display("[TB] FAIL mis_wl_mem_req got 1 want 0"); end
        checks++; if (o.rdata !== 32'd0) begin errors++; $display("[TB] FAIL mis_wl_rdata got %h want 0", o.rdata); end
        run_access(1'b1, 2'b01, 1'b0, 32'h3, 32'h5555AAAA, 0, o);
        checks++; if (o.mis !== 1'b1 || o.done_cyc != 1) begin
            errors++; $display("[TB] FAIL mis_hs got mis=%b cyc=%0d want mis=1 cyc=1", o.mis, o.done_cyc);
        end
        checks++; if (o.req_seen) begin errors++; $display("[TB] FAIL mis_hs_mem_req got 1 want 0"); end
    endtask

    task automatic test_timeout();
        obs_t o;
        preload(4, 32'hCAFE0123);
        run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, -1, o);
        checks++; if (o.req_cycles != TIMEOUT) begin errors++; $display("[TB] FAIL to_req_cycles got %0d want %0d", o.req_cycles, TIMEOUT); end
        checks++; if (o.done_cyc != TIMEOUT + 1) begin errors++; $display("[TB] FAIL to_latency got %0d want %0d", o.done_cyc, TIMEOUT + 1); end
        checks++; if (o.berr !== 1'b1) begin errors++; $display("[TB] FAIL to_bus_err got %b want 1", o.berr); end
        checks++; if (o.rdata !== 32'd0) begin errors++; $display("[TB] FAIL to_rdata got %h want 0", o.rdata); end
        run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, TIMEOUT - 1, o);
        checks++; if (o.berr !== 1'b0) begin errors++; $display("[TB] FAIL late_ack_bus_err got %b want 0", o.berr); end
        checks++; if (o.rdata !== 32'hCAFE0123) begin errors++; $display("[TB] FAIL late_ack_rdata got %h want cafe0123", o.rdata); end
        checks++; if (o.done_cyc != TIMEOUT + 1) begin errors++; $display("[TB] FAIL late_ack_latency got %0d want %0d", o.done_cyc, TIMEOUT + 1); end
    endtask

    task automatic test_ack_in_idle();
        @(negedge clk);
        mem_if.mem_ack = 1'b1;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        checks++; if (cpu_if.done !== 1'b0 || mem_if.mem_req !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_ack got done=%b req=%b want 0 0", cpu_if.done, mem_if.mem_req);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        @(negedge clk);
        cpu_if.req_valid = 1'b1; cpu_if.req_we = 1'b0; cpu_if.req_size = 2'b10;
        cpu_if.addr = 32'h40; cpu_if.wdata = 32'd0;
        @(negedge clk);
        checks++; if (mem_if.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_wait_req got %b want 1", mem_if.mem_req); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_if.mem_req !== 1'b0 || cpu_if.done !== 1'b0) begin
            errors++; $display("[TB] FAIL async_rst got req=%b done=%b want 0 0", mem_if.mem_req, cpu_if.done);
        end
        cpu_if.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        preload(8, 32'h01234567);
        preload(9, 32'h89ABCDEF);
        run_access(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 0, o);
        checks++; if (o.done_cyc != 2 || o.rdata !== 32'h01234567) begin
            errors++; $display("[TB] FAIL b2b_0 got cyc=%0d rdata=%h want cyc=2 rdata=01234567", o.done_cyc, o.rdata);
        end
        run_access(1'b1, 2'b00, 1'b0, 32'h25, 32'h000000A5, 0, o);
        ref_store(32'h25, 2'b00, 32'h000000A5);
        checks++; if (o.done_cyc != 2 || o.be !== 4'b0010) begin
            errors++; $display("[TB] FAIL b2b_1 got cyc=%0d be=%b want cyc=2 be=0010", o.done_cyc, o.be);
        end
        run_access(1'b0, 2'b10, 1'b0, 32'h24, 32'd0, 0, o);
        checks++; if (o.rdata !== 32'h89ABA5EF) begin
            errors++; $display("[TB] FAIL b2b_2 got rdata=%h want 89aba5ef", o.rdata);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        we, uns, mis;
        logic [1:0]  size;
        logic [31:0] a, wd, want;
        int          d;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom); uns = 1'($urandom); size = 2'($urandom);
            a = 32'($urandom_range(0, 255)); wd = $urandom; d = $urandom_range(0, 3);
            mis  = exp_mis(size, a[1:0]);
            want = (we || mis) ? 32'd0 : exp_load(ref_mem[a[7:2]], size, a[1:0], uns);
            run_access(we, size, uns, a, wd, d, o);
            if (we && !mis) ref_store(a, size, wd);
            checks++; if (o.done_cyc != (mis ? 1 : 2 + d)) begin
                errors++; $display("[TB] FAIL rnd_latency[%0d] got %0d want %0d", i, o.done_cyc, mis ? 1 : 2 + d);
            end
            checks++; if (o.mis !== mis || o.berr !== 1'b0) begin
                errors++; $display("[TB] FAIL rnd_flags[%0d] got mis=%b err=%b want mis=%b err=0", i, o.mis, o.berr, mis);
            end
            checks++; if (o.rdata !== want) begin
                errors++; $display("[TB] FAIL rnd_rdata[%0d] got %h want %h", i, o.rdata, want);
            end
            checks++; if (!o.stall_ok || o.req_seen == mis) begin
                errors++; $display("[TB] FAIL rnd_stall_req[%0d] got stall_ok=%0d req_seen=%0d want 1 %0d", i, o.stall_ok, o.req_seen, !mis);
            end
            if (!mis) begin
                checks++; if (o.maddr !== {a[31:2], 2'b00} || o.be !== exp_be(size, a[1:0]) || o.we !== we) begin
                    errors++; $display("[TB] FAIL rnd_bus[%0d] got addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                                       i, o.maddr, o.be, o.we, {a[31:2], 2'b00}, exp_be(size, a[1:0]), we);
                end
                if (we) begin
                    checks++; if (o.mwdata !== exp_wd(size, wd)) begin
                        errors++; $display("[TB] FAIL rnd_wdata[%0d] got %h want %h", i, o.mwdata, exp_wd(size, wd));
                    end
                end
            end
        end
    endtask

    initial begin
        cpu_if.req_valid = 1'b0; cpu_if.req_we = 1'b0; cpu_if.req_size = 2'b00;
        cpu_if.req_unsigned = 1'b0; cpu_if.addr = 32'd0; cpu_if.wdata = 32'd0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'd0;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_timeout();
        test_ack_in_idle();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
